// File: rtl/spigpio_ctrl.sv
// spigpio_ctrl: two-requester round-robin arbiter and SPI master that sends 8-bit
// frames to the GPIO shift-register slave, followed by one latch pulse with cs high.
module spigpio_ctrl #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  output logic [1:0] gnt,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       spi_sclk,
  output logic       spi_cs,
  output logic       spi_mosi,
  input  logic       spi_miso
);
  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, GAP} state_t;
  localparam logic [7:0] RELOAD   = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);
  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d, sh_q, sh_d, rx_q, rx_d, rdata_q, rdata_d, tk_q, tk_d;
  logic [3:0] bit_q, bit_d;
  logic [1:0] gnt_q, gnt_d;
  logic sclk_q, sclk_d, cs_q, cs_d, prio_q, prio_d, done_q, done_d;
  logic tick, win;
  assign tick = cnt_q == 8'd0;
  // win is the index of the requester that gets the next grant
  assign win = req[1] & (~req[0] | prio_q);
  always_comb begin
    state_d = state_q;
    cnt_d   = tick ? RELOAD : cnt_q - 8'd1;
    sh_d    = sh_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    tk_d    = tk_q;
    bit_d   = bit_q;
    gnt_d   = 2'b00;
    sclk_d  = sclk_q;
    cs_d    = cs_q;
    prio_d  = prio_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        if (|req) begin
          state_d = SHIFT;
          gnt_d   = win ? 2'b10 : 2'b01;
          sh_d    = win ? data1 : data0;
          prio_d  = ~win;
          cs_d    = 1'b0;
          bit_d   = 4'd0;
          cnt_d   = RELOAD;
        end
      end
      SHIFT: begin
        if (tick) begin
          sclk_d = ~sclk_q;
          if (sclk_q) begin
            rx_d  = {rx_q[6:0], spi_miso};
            sh_d  = {sh_q[6:0], 1'b0};
            bit_d = bit_q + 4'd1;
            if (bit_q == 4'd7) begin
              cs_d    = 1'b1;
              state_d = LATCH;
            end
          end
        end
      end
      LATCH: begin
        if (tick) begin
          sclk_d = ~sclk_q;
          if (sclk_q) begin
            state_d = GAP;
            tk_d    = 8'd0;
          end
        end
      end
      GAP: begin
        if (tick) begin
          tk_d = tk_q + 8'd1;
          if (tk_q == GAP_LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
            rdata_d = rx_q;
            tk_d    = 8'd0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      sh_q    <= 8'd0;
      rx_q    <= 8'd0;
      rdata_q <= 8'd0;
      tk_q    <= 8'd0;
      bit_q   <= 4'd0;
      gnt_q   <= 2'b00;
      sclk_q  <= 1'b0;
      cs_q    <= 1'b1;
      prio_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      tk_q    <= tk_d;
      bit_q   <= bit_d;
      gnt_q   <= gnt_d;
      sclk_q  <= sclk_d;
      cs_q    <= cs_d;
      prio_q  <= prio_d;
      done_q  <= done_d;
    end
  end
  // mosi is the top of the shift register while the frame is selected, else 0
  assign spi_mosi = ~cs_q & sh_q[7];
  assign spi_sclk = sclk_q;
  assign spi_cs   = cs_q;
  assign gnt      = gnt_q;
  assign done     = done_q;
  assign rdata    = rdata_q;
  assign busy     = state_q != IDLE;
endmodule

// File: tb/tb_spigpio_ctrl.sv
// tb_spigpio_ctrl: directed bench with a behavioural GPIO slave attached to the SPI pins.
module tb_spigpio_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, spi_miso = 1'b0;
  logic [1:0] req, gnt;
  logic [7:0] data0, data1, rdata;
  logic busy, done, spi_sclk, spi_cs, spi_mosi;
  logic [1:0] req_b, b_gnt;
  logic [7:0] data0_b, b_rdata;
  logic b_busy, b_done, b_sclk, b_cs, b_mosi;
  spigpio_ctrl #(.CLK_DIV(4), .CS_GAP(2)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .data0(data0), .data1(data1),
    .gnt(gnt), .busy(busy), .done(done), .rdata(rdata), .spi_sclk(spi_sclk),
    .spi_cs(spi_cs), .spi_mosi(spi_mosi), .spi_miso(spi_miso));
  spigpio_ctrl #(.CLK_DIV(1), .CS_GAP(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req_b), .data0(data0_b), .data1(8'h00),
    .gnt(b_gnt), .busy(b_busy), .done(b_done), .rdata(b_rdata), .spi_sclk(b_sclk),
    .spi_cs(b_cs), .spi_mosi(b_mosi), .spi_miso(1'b0));
  // slave model: shifts mosi on sclk rise with cs low, decodes on a rise with cs high
  function automatic logic [7:0] slave_dec(input logic [7:0] g, input logic [7:0] b);
    logic [7:0] r;
    if (b == 8'hFF) return {g[7:4], 4'hF};
    if (b == 8'hFE) return {4'hF, g[3:0]};
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction
  logic p_sclk = 1'b0, p_cs = 1'b1, p_mosi = 1'b0;
  logic [7:0] sh_s = 8'h00, gpio = 8'h00, pat = 8'h00, miso_sh = 8'h00;
  int rise_lo = 0, rise_hi = 0, cs_lo = 0, unstable = 0;
  always @(negedge clk) begin
    if (!spi_cs) cs_lo++;
    if (spi_sclk && !p_sclk) begin
      if (!spi_cs) begin
        sh_s = {sh_s[6:0], spi_mosi};
        rise_lo++;
      end else begin
        rise_hi++;
        gpio = slave_dec(gpio, sh_s);
      end
    end
    if (spi_sclk && spi_mosi !== p_mosi) unstable++;
    if (!spi_cs && p_cs) begin
      miso_sh = pat;
      spi_miso = pat[7];
    end else if (!spi_cs && !spi_sclk && p_sclk) begin
      miso_sh = {miso_sh[6:0], 1'b0};
      spi_miso = miso_sh[7];
    end
    p_sclk = spi_sclk;
    p_cs = spi_cs;
    p_mosi = spi_mosi;
  end
  logic pb = 1'b0;
  logic [7:0] shb = 8'h00;
  always @(negedge clk) begin
    if (b_sclk && !pb && !b_cs) shb = {shb[6:0], b_mosi};
    pb = b_sclk;
  end
  int checks = 0, errors = 0;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wait_gnt(output int n);
    n = 0;
    while (gnt === 2'b00 && n < 300) begin
      step();
      n++;
    end
  endtask
  task automatic wait_done(input int start, output int n);
    n = start;
    do begin
      step();
      n++;
    end while (done !== 1'b1 && n < 300);
  endtask
  logic [1:0] rr_exp [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  initial begin
    int n, r0, h0, c0, u0;
    rst_n = 1'b0; req = 2'b00; data0 = 8'h00; data1 = 8'h00; req_b = 2'b00; data0_b = 8'h00;
    step(); step();
    chk("rst_cs", spi_cs, 1); chk("rst_sclk", spi_sclk, 0); chk("rst_mosi", spi_mosi, 0);
    chk("rst_gnt", gnt, 0); chk("rst_done", done, 0); chk("rst_busy", busy, 0);
    chk("rst_rdata", rdata, 8'h00);
    rst_n = 1'b1;
    step();
    data0 = 8'hFF; pat = 8'hCB;
    r0 = rise_lo; h0 = rise_hi; c0 = cs_lo; u0 = unstable;
    req = 2'b01;
    wait_gnt(n);
    chk("ff_gnt", gnt, 2'b01); chk("ff_cs_low", spi_cs, 0); chk("ff_busy", busy, 1);
    req = 2'b00;
    step();
    chk("ff_gnt_pulse", gnt, 0);
    wait_done(1, n);
    chk("ff_done_cycle", n, 80); chk("ff_busy_at_done", busy, 0);
    chk("ff_rise_lo", rise_lo - r0, 8); chk("ff_rise_hi", rise_hi - h0, 1);
    chk("ff_cs_low_cycles", cs_lo - c0, 64); chk("ff_bits", sh_s, 8'hFF);
    chk("ff_gpio", gpio, 8'h0F); chk("ff_rdata", rdata, 8'hCB);
    chk("ff_mosi_stable", unstable - u0, 0);
    step();
    chk("ff_done_pulse", done, 0);
    data0 = 8'hAA; pat = 8'h3C; req = 2'b01;
    wait_gnt(n);
    req = 2'b00;
    wait_done(0, n);
    chk("aa_done_cycle", n, 80); chk("aa_bits", sh_s, 8'hAA);
    chk("aa_gpio", gpio, 8'h55); chk("aa_rdata", rdata, 8'h3C);
    data0 = 8'hFE; req = 2'b01;
    wait_gnt(n);
    req = 2'b00;
    wait_done(0, n);
    chk("fe_gpio", gpio, 8'hF5); chk("fe_mosi_stable", unstable - u0, 0);
    data0 = 8'h00; req = 2'b01;
    wait_gnt(n);
    req = 2'b00;
    h0 = rise_hi;
    repeat (30) step();
    rst_n = 1'b0;
    step();
    chk("mid_rst_cs", spi_cs, 1); chk("mid_rst_sclk", spi_sclk, 0);
    chk("mid_rst_busy", busy, 0); chk("mid_rst_done", done, 0);
    chk("mid_rst_rdata", rdata, 8'h00);
    step(); step();
    chk("mid_rst_gpio", gpio, 8'hF5); chk("mid_rst_no_latch", rise_hi - h0, 0);
    rst_n = 1'b1;
    step();
    data1 = 8'h0F; req = 2'b10;
    wait_gnt(n);
    chk("prio_gnt", gnt, 2'b10);
    req = 2'b00;
    wait_done(0, n);
    chk("prio_gpio", gpio, 8'hF0);
    data0 = 8'hFF; data1 = 8'hFE; req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(n);
      chk("rr_gnt", gnt, rr_exp[k]);
      if (k > 0) chk("rr_gap", n, 1);
      wait_done(0, n);
    end
    req = 2'b00;
    step();
    chk("rr_stop_gnt", gnt, 0); chk("rr_stop_busy", busy, 0);
    data0_b = 8'hA5; req_b = 2'b01;
    n = 0;
    while (b_gnt === 2'b00 && n < 300) begin
      step();
      n++;
    end
    chk("div1_gnt", b_gnt, 2'b01);
    req_b = 2'b00;
    step(); chk("div1_sclk1", b_sclk, 1);
    step(); chk("div1_sclk2", b_sclk, 0);
    step(); chk("div1_sclk3", b_sclk, 1);
    n = 3;
    while (b_done !== 1'b1 && n < 300) begin
      step();
      n++;
    end
    chk("div1_done_cycle", n, 19); chk("div1_bits", shb, 8'hA5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/spigpio_ctrl.md
# spigpio_ctrl

SPI master and two-requester round-robin arbiter that sequences 8-bit command frames into the SPI GPIO shift-register slave. Each frame drives chip-select low for exactly 8 SCLK periods, then issues one SCLK pulse with chip-select high so the slave decodes and updates its GPIO outputs. It sits between two on-chip requesters and the off-block SPI pins.

## Interface
- CLK_DIV, 4: clk cycles per SCLK half-period (one "tick"); legal range 1..255.
- CS_GAP, 2: ticks chip-select stays high after the latch pulse, before the next frame; legal range 1..255.

- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req  in  2  per-requester frame request; held until matching gnt.
- data0  in  8  frame byte from requester 0; sampled on the grant edge.
- data1  in  8  frame byte from requester 1; sampled on the grant edge.
- gnt  out  2  one-hot, one-cycle grant; data captured.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse on frame completion.
- rdata  out  8  bits captured from spi_miso during last SHIFT, first bit in [7].
- spi_sclk  out  1  SPI clock, idle low.
- spi_cs  out  1  chip-select, active low, idle high.
- spi_mosi  out  1  serial data, MSB of frame first.
- spi_miso  in  1  serial data from slave.

## Operation
- Tick generator: counter reloads to CLK_DIV-1 on entry to SHIFT, LATCH and GAP; tick when counter is 0. Inactive in IDLE.
- States: IDLE, SHIFT, LATCH, GAP.
- IDLE: cs=1, sclk=0, mosi=0. If any req bit is high, go to SHIFT.
  - Arbitration: on the same edge, grant the winner, load shift register with its data, set cs=0 and mosi=data[7], and clear the bit counter.
  - Arbitration rule: round-robin pointer prio. If both requests are high, grant prio. If only one is high, grant that one.
  - After any grant, prio = index of the non-granted requester (the other one).
- SHIFT: each tick toggles sclk.
  - On a tick making sclk 1→0: sample spi_miso into rdata shift, shift the data register left, mosi = new bit 7, increment the bit counter.
  - After the 8th falling tick: cs=1, mosi=0, go to LATCH.
- LATCH: cs=1. Tick 1 sets sclk=1; tick 2 sets sclk=0; then go to GAP. This yields exactly one rising edge with cs high.
- GAP: cs=1, sclk=0. After CS_GAP ticks, go to IDLE and assert done for that one cycle. rdata becomes valid at done and holds until the next done.
- Requests are not sampled outside IDLE. A req that is still high in the done cycle is granted on the next edge.
- Frame content is transmitted unmodified; the controller does no opcode decoding.
- Example mappings with the slave: 0xAA drives all 8 GPIOs bit-reversed; 0xFF sets GPIO[3:0]; 0xFE sets GPIO[7:4].

## Timing
- Reset values (rst_n low at an edge): state IDLE, cs=1, sclk=0, mosi=0, gnt=0, done=0, busy=0, rdata=0x00, prio=0, counters 0.
- Reset mid-frame: cs rises on the reset edge, with no latch pulse and no done. The partial frame is discarded and the slave's outputs are not updated by it.
- Let T = CLK_DIV. Grant edge = cycle 0.
  - gnt, cs low and busy are all high from cycle 0.
  - First sclk rise occurs at cycle T.
  - cs rises at cycle 16T.
  - Latch pulse spans cycles 17T..18T.
  - done occurs at cycle (18+CS_GAP)T, with busy low in the same cycle.
- Back-to-back: next gnt at earliest (18+CS_GAP)T+1.
- mosi only changes while sclk is low. It is stable for ≥T cycles before and after each rising edge.
- CLK_DIV=1: a tick occurs every cycle, sclk = clk/2, and the same sequence applies.

## Test plan
- CLK_DIV=4, CS_GAP=2, req=01, data0=0xFF:
  - gnt=01 for one cycle, mosi=1 for all 8 bits, cs low for exactly 64 cycles, 8 sclk rises while cs=0, 1 rise while cs=1, done at cycle 80.
  - Attached slave gives gpioout[3:0]=0xF.
- req=01 with data0=0xAA, then req=01 with data0=0xFE:
  - mosi pattern is 1,0,1,0,1,0,1,0.
  - Slave gpioout=0x55 after the first frame and 0xF5 after the second.
- req=11 held continuously: grants alternate 01,10,01,10; each new gnt arrives exactly 1 cycle after the previous done.
- spi_miso driven with pattern 1,1,0,0,1,0,1,1 per falling tick -> rdata=0xCB at done.
- rst_n low at cycle 30 of a frame:
  - Next edge gives cs=1, sclk=0, busy=0, no done, and slave gpioout unchanged.
  - After release, a fresh req=10 is granted with prio initially 0.
- CLK_DIV=1, CS_GAP=1: done at cycle 19 after the grant, sclk period 2 cycles, and frame bits correct.
